// File: rtl/arena_plotter_if.sv
// arena_plotter_if: bundle between the tron game logic and arena_plotter.
//   Game side (master) drives the tick/round controls and both head
//   coordinates; the plotter (slave) drives the VGA plot port, the death
//   flags and its status.
//   step, new_round         : single-cycle control pulses
//   p1_x/p1_y, p2_x/p2_y     : current head coordinates (x 8 bits, y 7 bits)
//   plot_x/plot_y/plot_colour/plot_en : one pixel write per plot_en cycle
//   p1_dead, p2_dead        : sticky per-round crash flags
//   round_over              : one-cycle pulse when a tick kills anyone
//   busy                    : plotter is clearing or evaluating a tick
interface arena_plotter_if;
  logic       step;
  logic       new_round;
  logic [7:0] p1_x;
  logic [6:0] p1_y;
  logic [7:0] p2_x;
  logic [6:0] p2_y;
  logic [7:0] plot_x;
  logic [6:0] plot_y;
  logic [2:0] plot_colour;
  logic       plot_en;
  logic       p1_dead;
  logic       p2_dead;
  logic       round_over;
  logic       busy;

  modport master (
    output step, new_round, p1_x, p1_y, p2_x, p2_y,
    input  plot_x, plot_y, plot_colour, plot_en,
    input  p1_dead, p2_dead, round_over, busy
  );

  modport slave (
    input  step, new_round, p1_x, p1_y, p2_x, p2_y,
    output plot_x, plot_y, plot_colour, plot_en,
    output p1_dead, p2_dead, round_over, busy
  );
endinterface

// File: rtl/arena_plotter.sv
// arena_plotter: sole pixel writer of the tron arena.
//   On every game tick it snapshots both heads, checks them against the walls,
//   each other and a 1-bit occupancy grid of drawn trail, records survivors
//   and plots them. On reset and on new_round it sweeps the arena interior to
//   the background colour and clears the occupancy grid.
// Ports:
//   CLOCK_50 : system clock
//   resetn   : synchronous, active-low reset
//   bus_if   : arena_plotter_if.slave (controls, heads, plot port, flags)
module arena_plotter #(
  parameter logic [7:0] X_MIN     = 8'd10,
  parameter logic [7:0] X_MAX     = 8'd149,
  parameter logic [6:0] Y_MIN     = 7'd17,
  parameter logic [6:0] Y_MAX     = 7'd108,
  parameter logic [2:0] P1_COLOUR = 3'b001,
  parameter logic [2:0] P2_COLOUR = 3'b100,
  parameter logic [2:0] BG_COLOUR = 3'b000
) (
  input logic            CLOCK_50,
  input logic            resetn,
  arena_plotter_if.slave bus_if
);

  typedef enum logic [2:0] {
    S_CLEAR, S_IDLE, S_RD1, S_EV1, S_RD2, S_EV2, S_FIN, S_DEAD
  } state_t;

  state_t     state_q;
  logic [7:0] cx_q;
  logic [6:0] cy_q;
  logic [7:0] s1x_q, s2x_q;
  logic [6:0] s1y_q, s2y_q;
  logic [7:0] plot_x_q;
  logic [6:0] plot_y_q;
  logic [2:0] plot_colour_q;
  logic       plot_en_q;
  logic       p1_dead_q, p2_dead_q;
  logic       round_over_q;
  logic       busy_q;

  // Occupancy grid, addressed {y, x}.
  logic        occ_mem [0:32767];
  logic        occ_rd_q;
  logic [14:0] rd_addr_d;
  logic [14:0] wr_addr_d;
  logic        wr_en_d;
  logic        wr_data_d;
  logic        head_on_d;
  logic        crash1_d, crash2_d;

  function automatic logic off_arena(input logic [7:0] x, input logic [6:0] y);
    return (x == X_MIN) || (x >= X_MAX) || (y == Y_MIN) || (y >= Y_MAX);
  endfunction

  always_comb begin
    // Only RD1 needs P1's address; in RD2 the P2 address is what gets read.
    rd_addr_d = (state_q == S_RD1) ? {s1y_q, s1x_q} : {s2y_q, s2x_q};
    head_on_d = (s1x_q == s2x_q) && (s1y_q == s2y_q);
    crash1_d  = off_arena(s1x_q, s1y_q) || occ_rd_q || head_on_d;
    crash2_d  = off_arena(s2x_q, s2y_q) || occ_rd_q || head_on_d;
    wr_en_d   = 1'b0;
    wr_addr_d = {cy_q, cx_q};
    wr_data_d = 1'b0;
    // A new_round in the same cycle drops whatever write this state wanted.
    if (resetn && !bus_if.new_round) begin
      case (state_q)
        S_CLEAR: wr_en_d = 1'b1;
        S_EV1: if (!crash1_d) begin
          wr_en_d   = 1'b1;
          wr_addr_d = {s1y_q, s1x_q};
          wr_data_d = 1'b1;
        end
        S_EV2: if (!crash2_d) begin
          wr_en_d   = 1'b1;
          wr_addr_d = {s2y_q, s2x_q};
          wr_data_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Registered-read block RAM; P1's write in EV1 is visible to the RD2 read.
  always_ff @(posedge CLOCK_50) begin
    if (wr_en_d) occ_mem[wr_addr_d] <= wr_data_d;
    occ_rd_q <= occ_mem[rd_addr_d];
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_q       <= S_CLEAR;
      cx_q          <= X_MIN + 8'd1;
      cy_q          <= Y_MIN + 7'd1;
      s1x_q         <= 8'd0;
      s1y_q         <= 7'd0;
      s2x_q         <= 8'd0;
      s2y_q         <= 7'd0;
      plot_x_q      <= 8'd0;
      plot_y_q      <= 7'd0;
      plot_colour_q <= 3'd0;
      plot_en_q     <= 1'b0;
      p1_dead_q     <= 1'b0;
      p2_dead_q     <= 1'b0;
      round_over_q  <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      plot_en_q    <= 1'b0;
      round_over_q <= 1'b0;
      if (bus_if.new_round) begin
        // Restart the sweep; dead flags survive until the sweep finishes.
        state_q <= S_CLEAR;
        cx_q    <= X_MIN + 8'd1;
        cy_q    <= Y_MIN + 7'd1;
        busy_q  <= 1'b1;
      end else begin
        case (state_q)
          S_CLEAR: begin
            plot_x_q      <= cx_q;
            plot_y_q      <= cy_q;
            plot_colour_q <= BG_COLOUR;
            plot_en_q     <= 1'b1;
            busy_q        <= 1'b1;
            if (cy_q == Y_MAX - 7'd1) begin
              cy_q <= Y_MIN + 7'd1;
              if (cx_q == X_MAX - 8'd1) begin
                cx_q      <= X_MIN + 8'd1;
                p1_dead_q <= 1'b0;
                p2_dead_q <= 1'b0;
                busy_q    <= 1'b0;
                state_q   <= S_IDLE;
              end else begin
                cx_q <= cx_q + 8'd1;
              end
            end else begin
              cy_q <= cy_q + 7'd1;
            end
          end
          S_IDLE: begin
            if (bus_if.step) begin
              s1x_q   <= bus_if.p1_x;
              s1y_q   <= bus_if.p1_y;
              s2x_q   <= bus_if.p2_x;
              s2y_q   <= bus_if.p2_y;
              busy_q  <= 1'b1;
              state_q <= S_RD1;
            end
          end
          S_RD1: state_q <= S_EV1;
          S_EV1: begin
            if (crash1_d) begin
              p1_dead_q <= 1'b1;
            end else begin
              plot_x_q      <= s1x_q;
              plot_y_q      <= s1y_q;
              plot_colour_q <= P1_COLOUR;
              plot_en_q     <= 1'b1;
            end
            state_q <= S_RD2;
          end
          S_RD2: state_q <= S_EV2;
          S_EV2: begin
            if (crash2_d) begin
              p2_dead_q <= 1'b1;
            end else begin
              plot_x_q      <= s2x_q;
              plot_y_q      <= s2y_q;
              plot_colour_q <= P2_COLOUR;
              plot_en_q     <= 1'b1;
            end
            state_q <= S_FIN;
          end
          S_FIN: begin
            busy_q <= 1'b0;
            if (p1_dead_q || p2_dead_q) begin
              round_over_q <= 1'b1;
              state_q      <= S_DEAD;
            end else begin
              state_q <= S_IDLE;
            end
          end
          S_DEAD: busy_q <= 1'b0;
          default: state_q <= S_CLEAR;
        endcase
      end
    end
  end

  assign bus_if.plot_x      = plot_x_q;
  assign bus_if.plot_y      = plot_y_q;
  assign bus_if.plot_colour = plot_colour_q;
  assign bus_if.plot_en     = plot_en_q;
  assign bus_if.p1_dead     = p1_dead_q;
  assign bus_if.p2_dead     = p2_dead_q;
  assign bus_if.round_over  = round_over_q;
  assign bus_if.busy        = busy_q;

endmodule
